// File: rtl/ann_dma_pkg.sv
// ann_dma_pkg: shared types, default burst limit and burst-length clipping for the DMA scheduler.
package ann_dma_pkg;
  localparam int BLK_MAX_DEF = 16;
  typedef enum logic [2:0] {IDLE, ARB, RD_WAIT, WR_WAIT, FIN} state_t;
  typedef enum logic {GNT_RD, GNT_WR} gnt_t;
  function automatic logic [4:0] clip_len(input logic [4:0] bs, input logic [31:0] rem, input logic [4:0] blk);
    logic [4:0] eff;
    eff = (bs == 5'd0) ? 5'd1 : (bs > blk) ? blk : bs;
    return (rem < 32'(eff)) ? rem[4:0] : eff;
  endfunction
endpackage

// File: rtl/ann_rr_arb2.sv
// ann_rr_arb2: two-requester round-robin arbiter; last grant is remembered only when i_adv is strobed.
module ann_rr_arb2 import ann_dma_pkg::*; (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rd,
  input  logic i_wr,
  input  logic i_adv,
  output logic o_gnt_rd,
  output logic o_gnt_wr
);
  gnt_t r_last;
  always_comb begin
    o_gnt_rd = i_rd && (!i_wr || r_last == GNT_WR);
    o_gnt_wr = i_wr && (!i_rd || r_last == GNT_RD);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_last <= GNT_WR;
    else if (i_adv && (o_gnt_rd || o_gnt_wr)) r_last <= o_gnt_rd ? GNT_RD : GNT_WR;
endmodule

// File: rtl/ann_dma_sched.sv
// ann_dma_sched: splits a DMA job into read/write bursts, arbitrates the two directions and reports completion.
module ann_dma_sched import ann_dma_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int BLK_MAX = BLK_MAX_DEF
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              start,
  input  logic              abort,
  input  logic              int_clr,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  rd_words,
  input  logic [CNT_W-1:0]  wr_words,
  input  logic [4:0]        block_size,
  input  logic [CNT_W-1:0]  fifo_free,
  input  logic [CNT_W-1:0]  out_avail,
  output logic              rd_req,
  output logic              wr_req,
  output logic [ADDR_W-1:0] req_addr,
  output logic [4:0]        req_len,
  input  logic              req_done,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              irq
);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr, r_req_addr;
  logic [CNT_W-1:0] r_rd_rem, r_wr_rem;
  logic [4:0] r_req_len, w_rd_len, w_wr_len;
  logic r_abort_pend, r_aborted, r_irq;
  logic w_rd_ok, w_wr_ok, w_gnt_rd, w_gnt_wr, w_wait, w_launch, w_take, w_fin_abort;

  assign w_rd_len    = clip_len(block_size, 32'(r_rd_rem), 5'(BLK_MAX));
  assign w_wr_len    = clip_len(block_size, 32'(r_wr_rem), 5'(BLK_MAX));
  assign w_rd_ok     = (r_rd_rem != '0) && (fifo_free >= CNT_W'(w_rd_len));
  assign w_wr_ok     = (r_wr_rem != '0) && (out_avail >= CNT_W'(w_wr_len));
  assign w_wait      = r_state inside {RD_WAIT, WR_WAIT};
  assign w_launch    = (r_state == IDLE) && start && !abort;
  assign w_take      = (r_state == ARB) && !abort && (w_gnt_rd || w_gnt_wr);
  // An abort seen mid-burst is deferred until the burst completes.
  assign w_fin_abort = ((r_state == ARB) && abort) || (w_wait && req_done && (abort || r_abort_pend));

  ann_rr_arb2 u_arb (
    .i_clk    (hclk),
    .i_rst_n  (hresetn),
    .i_rd     (w_rd_ok),
    .i_wr     (w_wr_ok),
    .i_adv    (w_take),
    .o_gnt_rd (w_gnt_rd),
    .o_gnt_wr (w_gnt_wr)
  );

  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:             w_next = w_launch ? ARB : IDLE;
      ARB:              w_next = (abort || (r_rd_rem == '0 && r_wr_rem == '0)) ? FIN :
                                 w_gnt_rd ? RD_WAIT : w_gnt_wr ? WR_WAIT : ARB;
      RD_WAIT, WR_WAIT: w_next = !req_done ? r_state : (abort || r_abort_pend) ? FIN : ARB;
      FIN:              w_next = IDLE;
      default:          w_next = IDLE;
    endcase
  end

  always_comb begin
    rd_req   = r_state == RD_WAIT;
    wr_req   = r_state == WR_WAIT;
    busy     = r_state inside {ARB, RD_WAIT, WR_WAIT};
    done     = r_state == FIN;
    req_addr = r_req_addr;
    req_len  = r_req_len;
    aborted  = r_aborted;
    irq      = r_irq;
  end

  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      r_rd_addr    <= '0;
      r_wr_addr    <= '0;
      r_rd_rem     <= '0;
      r_wr_rem     <= '0;
      r_req_addr   <= '0;
      r_req_len    <= '0;
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_launch) begin
        r_rd_addr <= src_base;
        r_wr_addr <= dst_base;
        r_rd_rem  <= rd_words;
        r_wr_rem  <= wr_words;
        r_aborted <= 1'b0;
      end
      if (w_take) begin
        r_req_addr <= w_gnt_rd ? r_rd_addr : r_wr_addr;
        r_req_len  <= w_gnt_rd ? w_rd_len : w_wr_len;
      end
      if (r_state == RD_WAIT && req_done) begin
        r_rd_rem  <= r_rd_rem - CNT_W'(r_req_len);
        r_rd_addr <= r_rd_addr + (ADDR_W'(r_req_len) << 2);
      end
      if (r_state == WR_WAIT && req_done) begin
        r_wr_rem  <= r_wr_rem - CNT_W'(r_req_len);
        r_wr_addr <= r_wr_addr + (ADDR_W'(r_req_len) << 2);
      end
      r_abort_pend <= w_wait && !req_done && (r_abort_pend || abort);
      if (w_fin_abort) r_aborted <= 1'b1;
      // Setting on entry and during FIN beats a coincident int_clr.
      r_irq <= (w_next == FIN || r_state == FIN) ? 1'b1 : int_clr ? 1'b0 : r_irq;
    end
endmodule

// File: tb/tb_ann_dma_sched.sv
// tb_ann_dma_sched: directed bench for the DMA burst scheduler with hand-computed burst sequences.
module tb_ann_dma_sched;
  logic        hclk = 1'b0, hresetn = 1'b0;
  logic        start = 1'b0, abort = 1'b0, int_clr = 1'b0, req_done = 1'b0;
  logic [31:0] src_base = '0, dst_base = '0, req_addr;
  logic [15:0] rd_words = '0, wr_words = '0, fifo_free = 16'd16, out_avail = 16'd16;
  logic [4:0]  block_size = 5'd4, req_len;
  logic        rd_req, wr_req, busy, done, aborted, irq;
  int          checks = 0, errors = 0;

  ann_dma_sched dut (
    .hclk(hclk), .hresetn(hresetn), .start(start), .abort(abort), .int_clr(int_clr),
    .src_base(src_base), .dst_base(dst_base), .rd_words(rd_words), .wr_words(wr_words),
    .block_size(block_size), .fifo_free(fifo_free), .out_avail(out_avail),
    .rd_req(rd_req), .wr_req(wr_req), .req_addr(req_addr), .req_len(req_len),
    .req_done(req_done), .busy(busy), .done(done), .aborted(aborted), .irq(irq)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] r,
                           input logic [15:0] w, input logic [4:0] b);
    src_base = s; dst_base = d; rd_words = r; wr_words = w; block_size = b;
    start = 1'b1;
    @(negedge hclk);
    start = 1'b0;
  endtask

  task automatic do_burst(input string tag, input logic is_wr, input logic [31:0] a, input logic [4:0] l);
    int k = 0;
    while (!(rd_req || wr_req) && k < 50) begin
      @(negedge hclk);
      k++;
    end
    chk({tag, " seen"}, 32'(rd_req | wr_req), 32'd1);
    chk({tag, " dir"}, 32'(wr_req), 32'(is_wr));
    chk({tag, " addr"}, req_addr, a);
    chk({tag, " len"}, 32'(req_len), 32'(l));
    @(negedge hclk);
    chk({tag, " hold"}, {30'd0, wr_req, rd_req}, is_wr ? 32'd2 : 32'd1);
    req_done = 1'b1;
    @(negedge hclk);
    req_done = 1'b0;
    chk({tag, " drop"}, 32'(rd_req | wr_req), 32'd0);
  endtask

  task automatic expect_fin(input string tag, input logic ab);
    @(negedge hclk);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " irq"}, 32'(irq), 32'd1);
    chk({tag, " aborted"}, 32'(aborted), 32'(ab));
    @(negedge hclk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic clear_irq();
    int_clr = 1'b1;
    @(negedge hclk);
    int_clr = 1'b0;
    chk("irq_clear", 32'(irq), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge hclk);
    chk("rst rd_req", 32'(rd_req), 0);
    chk("rst wr_req", 32'(wr_req), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst irq", 32'(irq), 0);
    chk("rst aborted", 32'(aborted), 0);
    chk("rst addr", req_addr, 0);
    chk("rst len", 32'(req_len), 0);
    hresetn = 1'b1;
    @(negedge hclk);

    // Two read bursts, first request one ARB cycle after start
    start_job(32'h1000, 32'h0, 16'd8, 16'd0, 5'd4);
    chk("t1 busy", 32'(busy), 1);
    chk("t1 arb_no_req", 32'(rd_req), 0);
    @(negedge hclk);
    chk("t1 first_req", 32'(rd_req), 1);
    do_burst("t1 b0", 1'b0, 32'h1000, 5'd4);
    do_burst("t1 b1", 1'b0, 32'h1010, 5'd4);
    expect_fin("t1", 1'b0);
    chk("t1 irq_sticky", 32'(irq), 1);
    clear_irq();

    // Fresh reset so the read side wins the first shared arbitration
    hresetn = 1'b0;
    @(negedge hclk);
    hresetn = 1'b1;
    start_job(32'h2000, 32'h3000, 16'd6, 16'd6, 5'd4);
    do_burst("t2 rd0", 1'b0, 32'h2000, 5'd4);
    do_burst("t2 wr0", 1'b1, 32'h3000, 5'd4);
    do_burst("t2 rd1", 1'b0, 32'h2010, 5'd2);
    do_burst("t2 wr1", 1'b1, 32'h3010, 5'd2);
    expect_fin("t2", 1'b0);

    start_job(32'h600, 32'h0, 16'd2, 16'd0, 5'd0);
    do_burst("t3 bs0 b0", 1'b0, 32'h600, 5'd1);
    do_burst("t3 bs0 b1", 1'b0, 32'h604, 5'd1);
    expect_fin("t3a", 1'b0);
    start_job(32'h0, 32'h4000, 16'd0, 16'd20, 5'd31);
    do_burst("t3 bs31 b0", 1'b1, 32'h4000, 5'd16);
    do_burst("t3 bs31 b1", 1'b1, 32'h4040, 5'd4);
    expect_fin("t3b", 1'b0);

    // Read gated by FIFO space
    fifo_free = 16'd3;
    start_job(32'h700, 32'h0, 16'd4, 16'd0, 5'd4);
    repeat (3) @(negedge hclk);
    chk("t4 gated", 32'(rd_req), 0);
    chk("t4 gated busy", 32'(busy), 1);
    fifo_free = 16'd4;
    @(negedge hclk);
    chk("t4 released", 32'(rd_req), 1);
    do_burst("t4 b0", 1'b0, 32'h700, 5'd4);
    expect_fin("t4", 1'b0);
    fifo_free = 16'd16;

    // Abort during RD_WAIT completes the burst, then finishes
    start_job(32'h5000, 32'h0, 16'd8, 16'd0, 5'd4);
    @(negedge hclk);
    chk("t5 req", 32'(rd_req), 1);
    abort = 1'b1;
    @(negedge hclk);
    abort = 1'b0;
    chk("t5 hold0", 32'(rd_req), 1);
    chk("t5 addr", req_addr, 32'h5000);
    @(negedge hclk);
    chk("t5 hold1", 32'(rd_req), 1);
    req_done = 1'b1;
    @(negedge hclk);
    req_done = 1'b0;
    chk("t5 drop", 32'(rd_req), 0);
    chk("t5 done", 32'(done), 1);
    chk("t5 aborted", 32'(aborted), 1);
    @(negedge hclk);
    chk("t5 idle", 32'(busy), 0);
    clear_irq();

    // Abort in ARB, with int_clr colliding with FIN
    fifo_free = 16'd0;
    start_job(32'h800, 32'h0, 16'd4, 16'd0, 5'd4);
    chk("t6 arb", 32'(rd_req), 0);
    abort = 1'b1;
    @(negedge hclk);
    abort = 1'b0;
    chk("t6 done", 32'(done), 1);
    chk("t6 aborted", 32'(aborted), 1);
    int_clr = 1'b1;
    @(negedge hclk);
    int_clr = 1'b0;
    chk("t6 irq_set_wins", 32'(irq), 1);
    clear_irq();
    fifo_free = 16'd16;

    // start+abort together in IDLE, stray req_done in IDLE
    start = 1'b1; abort = 1'b1; req_done = 1'b1;
    @(negedge hclk);
    start = 1'b0; abort = 1'b0; req_done = 1'b0;
    chk("t7 not_launched", 32'(busy), 0);
    chk("t7 aborted_kept", 32'(aborted), 1);
    start_job(32'h0, 32'h0, 16'd0, 16'd0, 5'd4);
    chk("t7 busy", 32'(busy), 1);
    chk("t7 aborted_cleared", 32'(aborted), 0);
    expect_fin("t7 empty", 1'b0);

    start_job(32'hFFFF_FFF8, 32'h0, 16'd4, 16'd0, 5'd2);
    do_burst("t8 b0", 1'b0, 32'hFFFF_FFF8, 5'd2);
    do_burst("t8 wrap", 1'b0, 32'h0000_0000, 5'd2);
    expect_fin("t8", 1'b0);

    // Asynchronous reset during WR_WAIT
    start_job(32'h0, 32'h100, 16'd0, 16'd4, 5'd4);
    @(negedge hclk);
    chk("t9 wr_req", 32'(wr_req), 1);
    #2 hresetn = 1'b0;
    #1;
    chk("t9 rst wr_req", 32'(wr_req), 0);
    chk("t9 rst busy", 32'(busy), 0);
    chk("t9 rst irq", 32'(irq), 0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    chk("t9 stays idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ann_dma_sched.md
# ann_dma_sched

Burst scheduler for the AHB ANN accelerator's DMA path. It sits between the slave register file and the AHB master. It splits a programmed job into input-read bursts (memory → input FIFO) and output-write bursts (NPU output → memory). It arbitrates round-robin between the two directions and gates each burst on FIFO space or output availability. On job completion or abort it reports status and raises a sticky interrupt.

## Interface
- ADDR_W, 32, address width
- CNT_W, 16, width of word counters
- BLK_MAX, 16, maximum burst length in words
- hclk  in  1  clock, all logic on rising edge
- hresetn  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; launches a job, ignored unless idle
- abort  in  1  single-cycle pulse; stops scheduling new bursts
- int_clr  in  1  clears irq
- src_base  in  ADDR_W  byte address of first input word
- dst_base  in  ADDR_W  byte address of first output word
- rd_words  in  CNT_W  total input words
- wr_words  in  CNT_W  total output words
- block_size  in  5  requested burst length in words
- fifo_free  in  CNT_W  free entries in the input FIFO
- out_avail  in  CNT_W  NPU output words ready to drain
- rd_req  out  1  read burst request, level
- wr_req  out  1  write burst request, level
- req_addr  out  ADDR_W  burst start byte address
- req_len  out  5  burst length in words, 1..BLK_MAX
- req_done  in  1  single-cycle pulse from the AHB master: burst finished
- busy  out  1  job in progress
- done  out  1  single-cycle pulse at job end
- aborted  out  1  last job ended by abort; cleared on next start
- irq  out  1  sticky; set with done, cleared by int_clr

## Operation
- Reset: all outputs 0, state IDLE, counters 0, last-grant = WRITE, so the first grant goes to read.
- blk_eff = 1 if block_size==0; BLK_MAX if block_size>BLK_MAX; otherwise block_size.
- States:
  - IDLE: start → load rd_addr=src_base, wr_addr=dst_base, rd_rem=rd_words, wr_rem=wr_words; clear aborted; busy=1; go to ARB.
  - ARB:
    - rd_len = min(blk_eff, rd_rem); wr_len = min(blk_eff, wr_rem).
    - rd_ok = rd_rem≠0 and fifo_free ≥ rd_len.
    - wr_ok = wr_rem≠0 and out_avail ≥ wr_len.
    - Both ok → grant the direction opposite last-grant. One ok → grant it. Neither → stay in ARB.
    - On grant, register req_addr/req_len, assert rd_req or wr_req, update last-grant, go to RD_WAIT or WR_WAIT.
    - rd_rem==0 and wr_rem==0 → go to FIN.
  - RD_WAIT / WR_WAIT:
    - Hold the request and req_addr/req_len stable until req_done.
    - On the req_done edge: drop the request, subtract len from the remaining count, add 4·len to the address, return to ARB.
  - FIN: done=1 for one cycle, irq=1, busy=0, go to IDLE.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around is silent.
- Abort:
  - In ARB: go to FIN next cycle with aborted=1.
  - In a WAIT state: keep the request until req_done, update counters, then go to FIN with aborted=1. An in-flight burst is never truncated.
  - In IDLE or FIN: ignored.
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins; the job is not launched.
- rd_words=wr_words=0: IDLE→ARB→FIN; done pulses 2 cycles after start.
- int_clr and FIN in the same cycle: set wins, irq stays 1.
- req_done outside a WAIT state: ignored.

## Timing
- start at edge N → busy=1 after N. The first request is asserted after N+1 if eligible (one ARB cycle).
- req_done at edge M → request low after M, ARB during cycle M+1. The next request is asserted after M+1 at the earliest. Minimum idle gap between bursts is one cycle.
- fifo_free and out_avail are sampled only in ARB.
- Reset asserted mid-burst: the request drops asynchronously and all state returns to reset values.

## Structure
- Package ann_dma_pkg holds:
  - state enum {IDLE, ARB, RD_WAIT, WR_WAIT, FIN}
  - BLK_MAX default
  - grant-direction enum
  - function clip_len(block_size, remaining)
- Sub-module ann_rr_arb2: 2-requester round-robin arbiter with a registered last-grant and an advance strobe. Everything else stays in ann_dma_sched.

## Test plan
- rd_words=8, wr_words=0, block_size=4, fifo_free=16, src_base=0x1000 → two read bursts at 0x1000 and 0x1010, len 4. Then done, irq=1.
- rd_words=6, wr_words=6, block_size=4, fifo_free=16, out_avail=16 → grant order RD(0x..,4), WR(4), RD(2), WR(2). Each write starts at dst_base and advances by 16 bytes.
- block_size=0 → req_len=1 on every burst. block_size=31 → req_len=16.
- fifo_free=3 with rd_len=4 → no rd_req until fifo_free=4; rd_req asserts the cycle after the change.
- Abort during RD_WAIT → rd_req holds until req_done, then done pulses with aborted=1, and rd_rem reflects the completed burst.
- src_base=0xFFFFFFF8, rd_words=4, block_size=2 → second burst at 0x00000000. A reset during WR_WAIT drops wr_req and busy immediately.
